// File: rtl/nibble_operand_loader_pkg.sv
// Shared definitions for the nibble operand loader and the adder top that
// consumes its packed operand word.
//   DEFAULT_WIDTH       : operand width in bits (packed word is twice this)
//   DEFAULT_SYNC_STAGES : flops per input synchroniser (two or more)
//   state_e             : loader FSM encoding, visible on state_o
package nibble_operand_loader_pkg;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_HAVE_A = 2'b01,
    ST_FULL   = 2'b10
  } state_e;

endpackage

// File: rtl/nibble_operand_loader_sync_edge_detect.sv
// N-stage synchroniser with a rising-edge pulse per bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input bits
//   q          : synchronised bits (last stage of the chain)
//   rise       : one-cycle pulse per bit, high in the cycle q first shows 1
// STAGES must be at least 2 for metastability protection.
module nibble_operand_loader_sync_edge_detect
  import nibble_operand_loader_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] chain;
  logic [WIDTH-1:0]             prev;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its predecessor held before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = chain[STAGES-1] & ~prev;

endmodule

// File: rtl/nibble_operand_loader.sv
// Operand-capture stage for the nibble adder. Two successive rising edges on
// the load pin capture operand A then operand B; the pair is offered as one
// packed word with a valid/ready handshake.
//   clk, rst_n   : clock, asynchronous active-low reset
//   data_in      : operand nibble from pins (asynchronous)
//   load_in      : load strobe from pin (asynchronous level)
//   clear_in     : synchronous clear, already in the clk domain
//   out_ready    : downstream accepts the word
//   out_valid    : packed operand pair valid
//   out_operands : {A, B}
//   state_o      : FSM state (00 EMPTY, 01 HAVE_A, 10 FULL)
//   overrun_o    : sticky, a load edge was dropped while FULL
module nibble_operand_loader
  import nibble_operand_loader_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               load_in,
  input  logic               clear_in,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out_operands,
  output logic [1:0]         state_o,
  output logic               overrun_o
);

  logic             load_pulse;
  logic             load_level_unused;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_edge_unused;

  // Data and strobe go through identical chains, so data_sync is aligned
  // with load_pulse.
  nibble_operand_loader_sync_edge_detect #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_load_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (load_in),
    .q     (load_level_unused),
    .rise  (load_pulse)
  );

  nibble_operand_loader_sync_edge_detect #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_data_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (data_in),
    .q     (data_sync),
    .rise  (data_edge_unused)
  );

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] ops_q, ops_d;
  logic               overrun_q, overrun_d;

  // NOTE: every operand register is reset, so an interrupted capture can never
  // leak a stale operand into a later word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      a_q       <= '0;
      ops_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      ops_q     <= ops_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: every output of this block is given its hold value first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    ops_d     = ops_q;
    overrun_d = overrun_q;
    if (clear_in) begin
      // Clear beats any load or handshake; captured operands are retained.
      state_d   = ST_EMPTY;
      overrun_d = 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load_pulse) begin
            a_d     = data_sync;
            state_d = ST_HAVE_A;
          end
        end
        ST_HAVE_A: begin
          if (load_pulse) begin
            ops_d   = {a_q, data_sync};
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            // Word leaves; a coincident load starts the next pair.
            if (load_pulse) begin
              a_d     = data_sync;
              state_d = ST_HAVE_A;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (load_pulse) begin
            overrun_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Valid comes straight from the state register, never from out_ready.
  assign out_valid    = (state_q == ST_FULL);
  assign out_operands = ops_q;
  assign state_o      = state_q;
  assign overrun_o    = overrun_q;

endmodule

// File: doc/nibble_operand_loader.md
Name: nibble_operand_loader

Overview:
Upstream operand-capture stage for the nibble adder. It takes a 4-bit operand from the input pins and a pin-driven load strobe. The strobe is synchronised and edge-detected. Two successive strobes capture operand A, then operand B. The pair is presented as one packed 8-bit word with a valid/ready handshake, and the adder stage consumes it directly as its two nibble inputs.

Parameters:
WIDTH, 4, operand width in bits; output word is 2*WIDTH
SYNC_STAGES, 2, flops in each input synchroniser (min 2)

Ports:
clk  input  1  single clock
rst_n  input  1  asynchronous active-low reset
data_in  input  WIDTH  operand nibble from pins, asynchronous
load_in  input  1  load strobe from pin, asynchronous, level; each rising edge loads one operand
clear_in  input  1  synchronous clear, already in clk domain
out_ready  input  1  downstream accepts word
out_valid  output  1  packed operand pair valid
out_operands  output  2*WIDTH  [2W-1:W]=operand A, [W-1:0]=operand B
state_o  output  2  FSM state: 00 EMPTY, 01 HAVE_A, 10 FULL
overrun_o  output  1  sticky flag: a load edge arrived while FULL and was dropped

Behaviour:
- Reset is asynchronous on rst_n low, with synchronous release on clk. While in reset:
  - all synchroniser flops and the edge-detect history flop = 0
  - state = EMPTY, A = B = 0
  - out_valid = 0, out_operands = 0, overrun_o = 0
- Reset mid-operation discards captured operands. No word is emitted.
- Synchronisers:
  - load_in and data_in each pass through SYNC_STAGES flops.
  - load_pulse = sync_load_last & ~load_prev; load_prev is one more flop.
  - The capture uses the synchronised data, aligned with load_pulse.
- Latency: load_in first sampled high at edge N -> load_pulse high in the cycle after edge N+SYNC_STAGES-1 -> register/state update at edge N+SYNC_STAGES.
- A held-high load_in produces exactly one pulse. Glitches shorter than one clk may be missed; this is accepted.
- FSM, evaluated in priority order each edge:
  1. clear_in = 1 -> EMPTY; out_valid = 0; overrun cleared; A and B keep their values. This overrides load_pulse and the handshake.
  2. EMPTY, load_pulse -> capture A; go to HAVE_A.
  3. HAVE_A, load_pulse -> capture B; go to FULL; out_valid = 1 from the next cycle.
  4. FULL, out_valid & out_ready, no load_pulse -> EMPTY; out_valid = 0 next cycle.
  5. FULL, out_ready & load_pulse in the same cycle -> word accepted; new A captured; go to HAVE_A.
  6. FULL, load_pulse, out_ready = 0 -> pulse dropped; overrun_o = 1 (sticky until clear_in or reset); state stays FULL.
  7. Otherwise hold.
- Handshake:
  - out_operands is registered and updated only on the B capture.
  - It is stable while out_valid = 1 and out_ready = 0.
  - out_valid does not depend combinationally on out_ready.
  - out_ready is ignored when out_valid = 0.
- Arithmetic: none. Width rule: out_operands = {A, B}, exactly 2*WIDTH bits, no extension.
- state_o is driven directly from the state register. The unused encoding 11 recovers to EMPTY on the next edge.

Decomposition:
- Shared package holds:
  - state typedef/constants: ST_EMPTY = 2'b00, ST_HAVE_A = 2'b01, ST_FULL = 2'b10
  - default WIDTH and SYNC_STAGES constants, shared with the adder top
- One natural sub-module: sync_edge_detect, an N-stage synchroniser plus rising-edge pulse generator. It is instantiated once for load_in. data_in uses a plain N-stage synchroniser, instantiated from the same sub-module with the edge output unused.

Test Plan:
- Basic load: after reset, data_in = 4'h3 with a load_in rising edge; hold 5 cycles; data_in = 4'h9 with a second rising edge; out_ready = 0 -> state_o 00 -> 01 -> 10; out_valid = 1; out_operands = 8'h39. Check that each state change occurs SYNC_STAGES edges after load_in is first sampled high.
- Handshake: from FULL with 8'h39, hold out_ready = 0 for 4 cycles, then raise it -> out_operands stays 8'h39 and out_valid stays 1 throughout; one cycle after the accept edge out_valid = 0 and state_o = 00.
- Overrun and simultaneous events:
  - FULL with out_ready = 0; new load edge with data_in = 4'hF -> overrun_o = 1, out_operands stays 8'h39, state stays 10.
  - Repeat with out_ready = 1 in the pulse cycle -> word accepted, state_o = 01, new A = 4'hF, overrun_o unchanged.
- Held strobe: load_in held high for 20 cycles with data_in = 4'h5 -> exactly one capture; state_o = 01 only.
- Clear priority: in HAVE_A, assert clear_in in the same cycle as load_pulse -> state_o = 00, overrun_o = 0, out_valid = 0; the B capture does not occur.
- Async reset mid-operation: assert rst_n = 0 between clock edges while FULL -> out_valid, out_operands, state_o and overrun_o go to 0 immediately, without waiting for an edge; after release, a single load_in edge yields state_o = 01, not FULL.
